// File: rtl/disp_pkg.sv
// Shared definitions for the 4-digit 7-segment scan driver.
// Segment constants are active-low, ordered {g,f,e,d,c,b,a}.
package disp_pkg;

    localparam int unsigned DIG_W   = 4;
    localparam int unsigned NUM_DIG = 4;
    localparam int unsigned SEG_W   = 7;

    localparam logic [SEG_W-1:0] SEG_0    = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1    = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2    = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3    = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4    = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5    = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6    = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7    = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8    = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9    = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_DASH = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_OFF  = 7'b1111111;

    typedef enum logic {
        GUARD = 1'b0,
        SHOW  = 1'b1
    } slot_state_t;

    // Registered display drive: anodes, segments, decimal point (all active-low).
    typedef struct packed {
        logic [NUM_DIG-1:0] an;
        logic [SEG_W-1:0]   seg;
        logic               dp;
    } disp_out_t;

    localparam disp_out_t DISP_BLANK = '{an: 4'hF, seg: SEG_OFF, dp: 1'b1};

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to 7-segment decoder; values above 9 show a dash.
// Ports:
//   bcd   in  4  BCD nibble
//   seg_c out 7  active-low segments {g,f,e,d,c,b,a}
module bcd_to_seg
    import disp_pkg::*;
(
    input  logic [DIG_W-1:0] bcd,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_DASH;
        case (bcd)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/digit_display_scan.sv
// Time-multiplexed 4-digit 7-segment driver for the MM:SS display.
// Incoming digits are held in a shadow register that only updates on frame
// wrap, so a frame never mixes old and new digits.
// Optional feature: define DISP_BLINK_EN to enable per-digit blinking.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   digits        in  16  BCD {d3,d2,d1,d0}, d0 = seconds units
//   digits_valid  in  1   capture strobe for digits
//   blink_sel     in  4   per-digit blink request (ignored without DISP_BLINK_EN)
//   an            out 4   anode enables, active-low
//   seg           out 7   segments {g,f,e,d,c,b,a}, active-low
//   dp            out 1   decimal point, active-low, lit on digit 2
//   frame_start   out 1   pulse in the cycle after slot 3 -> 0 wrap
module digit_display_scan
    import disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 1000,
    parameter int unsigned GUARD_CYC = 2,
    parameter int unsigned BLINK_DIV = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_DIG*DIG_W-1:0] digits,
    input  logic                     digits_valid,
    input  logic [NUM_DIG-1:0]       blink_sel,
    output logic [NUM_DIG-1:0]       an,
    output logic [SEG_W-1:0]         seg,
    output logic                     dp,
    output logic                     frame_start
);

    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam int unsigned DW = NUM_DIG * DIG_W;
    localparam slot_state_t STATE_RST = (GUARD_CYC > 0) ? GUARD : SHOW;

    logic [PW-1:0]    pcnt;
    logic [PW-1:0]    pcnt_nxt;
    logic [1:0]       idx;
    logic             tick;
    logic             wrap;
    slot_state_t      state_q;
    slot_state_t      state_nxt;
    logic [DW-1:0]    shadow;
    logic [DW-1:0]    pend_data;
    logic             pend;
    logic             blank;
    logic [DIG_W-1:0] nib;
    logic [SEG_W-1:0] dec_seg;
    disp_out_t        out_nxt;
    disp_out_t        out_q;

    assign tick = (pcnt == PW'(SCAN_DIV - 1));
    assign wrap = tick && (idx == 2'd3);

    // Prescaler and slot index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
            idx  <= 2'd0;
        end else begin
            pcnt <= pcnt_nxt;
            if (tick) begin
                idx <= idx + 2'd1;
            end
        end
    end

    // Capture and frame-aligned shadow update; a strobe in the wrap cycle bypasses pend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow    <= '0;
            pend_data <= '0;
            pend      <= 1'b0;
        end else if (wrap) begin
            pend <= 1'b0;
            if (digits_valid) begin
                shadow <= digits;
            end else if (pend) begin
                shadow <= pend_data;
            end
        end else if (digits_valid) begin
            pend      <= 1'b1;
            pend_data <= digits;
        end
    end

`ifdef DISP_BLINK_EN
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] bcnt;
    logic          bphase;

    // Blink phase toggles every BLINK_DIV frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt   <= '0;
            bphase <= 1'b0;
        end else if (wrap) begin
            if (bcnt == BW'(BLINK_DIV - 1)) begin
                bcnt   <= '0;
                bphase <= ~bphase;
            end else begin
                bcnt <= bcnt + BW'(1);
            end
        end
    end

    assign blank = bphase && blink_sel[idx];
`else
    logic blink_unused;

    assign blink_unused = ^blink_sel;
    assign blank        = 1'b0;
`endif

    assign nib = shadow[{idx, 2'b00} +: DIG_W];

    bcd_to_seg u_dec (
        .bcd   (nib),
        .seg_c (dec_seg)
    );

    // Slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STATE_RST;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next slot state and display drive for the current slot.
    always_comb begin
        pcnt_nxt  = tick ? '0 : pcnt + PW'(1);
        state_nxt = (pcnt_nxt < PW'(GUARD_CYC)) ? GUARD : SHOW;
        out_nxt   = DISP_BLANK;
        case (state_q)
            GUARD: out_nxt = DISP_BLANK;
            SHOW: begin
                out_nxt.an  = blank ? 4'hF : ~(4'b0001 << idx);
                out_nxt.seg = dec_seg;
                out_nxt.dp  = (idx != 2'd2);
            end
            default: out_nxt = DISP_BLANK;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= DISP_BLANK;
            frame_start <= 1'b0;
        end else begin
            out_q       <= out_nxt;
            frame_start <= wrap;
        end
    end

    assign an  = out_q.an;
    assign seg = out_q.seg;
    assign dp  = out_q.dp;

endmodule

// File: tb/tb_digit_display_scan.sv
// Self-checking bench for digit_display_scan: directed scenarios plus random
// strobes, compared every cycle against a frame-arithmetic reference model.
module tb_digit_display_scan;

    localparam int unsigned SCAN_DIV  = 4;
    localparam int unsigned GUARD_CYC = 1;
    localparam int unsigned BLINK_DIV = 2;
    localparam int unsigned FRAME     = 4 * SCAN_DIV;
    localparam int          HMAX      = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits = 16'h0000;
    logic        digits_valid = 1'b0;
    logic [3:0]  blink_sel = 4'h0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    always #5 clk = ~clk;

    digit_display_scan #(
        .SCAN_DIV  (SCAN_DIV),
        .GUARD_CYC (GUARD_CYC),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .digits       (digits),
        .digits_valid (digits_valid),
        .blink_sel    (blink_sel),
        .an           (an),
        .seg          (seg),
        .dp           (dp),
        .frame_start  (frame_start)
    );

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int          n      = 0;   // cycles since reset release
    logic        vh [HMAX];
    logic [15:0] dh [HMAX];
    logic [3:0]  bh [HMAX];
    logic [6:0]  seg_tab [16];
    logic [3:0]  cur_blink = 4'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle=%0d got=%h exp=%h", tag, n, got, exp);
    endtask

    // Digits visible in frame f: last strobe sampled up to and including the wrap cycle ending frame f-1.
    function automatic logic [15:0] shadow_of(input int f);
        if (f == 0) return 16'h0000;
        for (int c = int'(FRAME) * f - 1; c >= 0; c--) begin
            if (vh[c]) return dh[c];
        end
        return 16'h0000;
    endfunction

    function automatic logic bphase_of(input int f);
`ifdef DISP_BLINK_EN
        return ((f / int'(BLINK_DIV)) % 2) == 1;
`else
        return (f < 0);
`endif
    endfunction

    task automatic check_outputs;
        int m, p, i, f;
        logic [15:0] sh;
        logic [3:0]  ean;
        logic [6:0]  eseg;
        logic        edp, efs;
        ean = 4'hF; eseg = 7'h7F; edp = 1'b1; efs = 1'b0;
        if (n > 0) begin
            m   = n - 1;
            p   = m % int'(SCAN_DIV);
            i   = (m / int'(SCAN_DIV)) % 4;
            f   = m / int'(FRAME);
            efs = (m % int'(FRAME)) == int'(FRAME) - 1;
            if (p >= int'(GUARD_CYC)) begin
                sh     = shadow_of(f);
                eseg   = seg_tab[sh[4*i +: 4]];
                edp    = (i != 2);
                ean[i] = 1'b0;
                if (bphase_of(f) && bh[m][i]) ean = 4'hF;
            end
        end
        check("an", 32'(an), 32'(ean));
        check("seg", 32'(seg), 32'(eseg));
        check("dp", 32'(dp), 32'(edp));
        check("frame_start", 32'(frame_start), 32'(efs));
    endtask

    task automatic step(input logic v, input logic [15:0] d);
        if (n >= HMAX - 1) begin
            $display("FAIL history_overflow cycle=%0d got=%0d exp=<%0d", n, n, HMAX - 1);
            $fatal(1, "history overflow");
        end
        digits_valid = v;
        digits       = d;
        blink_sel    = cur_blink;
        vh[n] = v; dh[n] = d; bh[n] = cur_blink;
        @(posedge clk);
        #1;
        n++;
        check_outputs();
    endtask

    task automatic idle(input int cnt);
        for (int k = 0; k < cnt; k++) step(1'b0, 16'($urandom));
    endtask

    task automatic align(input int phase);
        int guard_cnt;
        guard_cnt = 0;
        while ((n % int'(FRAME)) != phase && guard_cnt < 64) begin
            step(1'b0, 16'($urandom));
            guard_cnt++;
        end
    endtask

    task automatic release_reset;
        for (int k = 0; k < HMAX; k++) begin
            vh[k] = 1'b0; dh[k] = 16'h0; bh[k] = 4'h0;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        check_outputs();
    endtask

    initial begin
        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        for (int k = 10; k < 16; k++) seg_tab[k] = 7'b0111111;

        // Reset and idle scan of zeros.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_an", 32'(an), 32'h0000_000F);
        check("rst_seg", 32'(seg), 32'h0000_007F);
        release_reset();
        idle(20);

        // Mid-frame strobe appears only after the next wrap.
        align(6);
        step(1'b1, 16'h5930);
        idle(40);

        // Two strobes in one frame: last one wins.
        align(3);
        step(1'b1, 16'h1234);
        idle(4);
        step(1'b1, 16'h4321);
        idle(40);

        // Strobe in the wrap cycle overrides an earlier pending one.
        align(10);
        step(1'b1, 16'h1111);
        align(15);
        step(1'b1, 16'h8765);
        idle(20);

        // Out-of-range nibble shows a dash.
        align(4);
        step(1'b1, 16'h00A0);
        idle(32);

        // Blink digits 2 and 3 across several frames.
        cur_blink = 4'b1100;
        idle(5 * int'(FRAME));
        cur_blink = 4'b0000;

        // Random strobes and blink requests.
        for (int k = 0; k < 600; k++) begin
            if (($urandom % 32) == 0) cur_blink = 4'($urandom);
            step(($urandom % 8) == 0, 16'($urandom));
        end

        // Reset during slot 2 SHOW with a capture still pending.
        align(2);
        step(1'b1, 16'h9999);
        align(11);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_an", 32'(an), 32'h0000_000F);
        check("async_rst_seg", 32'(seg), 32'h0000_007F);
        check("async_rst_dp", 32'(dp), 32'h0000_0001);
        check("async_rst_fs", 32'(frame_start), 32'h0000_0000);
        digits_valid = 1'b0;
        cur_blink = 4'b0000;
        release_reset();
        idle(3 * int'(FRAME));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
